uart_rx_core: RTL
=================

// Module: uart_rx_core
// PURPOSE
//  UART receiver. Companion to the UART TX path; decodes the same frame:
//  start(0), DATA_WIDTH data bits LSB first, optional parity, one stop(1).
//  i_clk is the oversampled clock, at OVERSAMPLE ticks per bit.
//  Delivers the received byte and error flags to the host side as a 1-cycle pulse.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame
//  OVERSAMPLE  8  i_clk cycles per bit; must be >=4 and even
// PORTS
//  i_clk            in   1           oversampled clock
//  i_rst            in   1           async reset, active-low
//  i_rx_in          in   1           serial line, idle high, asynchronous
//  i_parity_enable  in   1           1: frame carries a parity bit
//  i_parity_type    in   1           0: even, 1: odd
//  o_data           out  DATA_WIDTH  last received data word
//  o_data_valid     out  1           1-cycle pulse: good frame in o_data
//  o_parity_error   out  1           1-cycle pulse: parity mismatch
//  o_stop_error     out  1           1-cycle pulse: stop bit sampled 0
//  o_busy           out  1           high while a frame is in progress
// BEHAVIOUR
//  Reset (async, i_rst=0):
//   - FSM returns to IDLE; all outputs are 0; o_data is 0.
//   - Synchronizer flops reset to 1; counters clear.
//   - Applies mid-frame with no output pulse.
//  Synchronizer: i_rx_in passes through 2 flops (rx_s); all logic uses rx_s.
//  Counters:
//   - edge_cnt runs 0..OVERSAMPLE-1 within each bit, then wraps to 0.
//   - bit_cnt counts data bits 0..DATA_WIDTH-1.
//  Sampling: each bit value is the majority of rx_s at edge_cnt = H-1, H, H+1,
//   where H = OVERSAMPLE/2.
//  FSM: IDLE, START, DATA, PARITY, STOP.
//   - IDLE: o_busy=0. On rx_s==0, go to START with edge_cnt=0.
//     Latch i_parity_enable and i_parity_type at this transition; they are
//     ignored for the rest of the frame.
//   - START: at edge_cnt=H+1, if the majority is 1 the start is a glitch:
//     go to IDLE with no pulse. Otherwise, at edge_cnt=OVERSAMPLE-1 go to DATA.
//   - DATA: at edge_cnt=H+1, shift the majority bit into the shift register
//     MSB end; this yields LSB-first order.
//     At edge_cnt=OVERSAMPLE-1: if bit_cnt=DATA_WIDTH-1, go to PARITY when
//     parity is latched enabled, else to STOP. Otherwise bit_cnt++.
//   - PARITY: capture the majority bit.
//     Expected bit = XOR(data), or its inverse when odd parity is selected.
//     At edge_cnt=OVERSAMPLE-1 go to STOP.
//   - STOP: capture the majority bit. At edge_cnt=OVERSAMPLE-1 go to IDLE,
//     and in that same transition cycle register the results:
//     o_data <= shift reg (always updated);
//     o_stop_error <= stop bit==0; o_parity_error <= parity enabled && mismatch;
//     o_data_valid <= neither error.
//     All pulses are high for exactly the next cycle.
//  o_busy is high in START, DATA, PARITY and STOP.
//  Frame length: (2 + DATA_WIDTH + P) * OVERSAMPLE cycles from IDLE exit,
//   where P=1 if parity is enabled. The pulse follows 1 cycle later.
//  Back-to-back frames:
//   - A start edge in the first IDLE cycle after STOP is accepted.
//   - If the line is already low there (stop error), a new frame starts.
//   - Line held low (break): repeated frames with stop errors; no lockup.
// TESTING (DATA_WIDTH=8, OVERSAMPLE=8)
//  1. No parity, send 0xA5 -> o_data=0xA5, one-cycle o_data_valid=1,
//     both errors 0; pulse 80 cycles after IDLE exit +1.
//  2. Even parity, 0x53 with parity bit 0 -> valid=1. Same frame with parity
//     bit 1 -> o_parity_error=1, valid=0, o_data=0x53.
//  3. Odd parity, 0x00 with parity 1 -> valid. Stop bit driven 0 ->
//     o_stop_error=1, valid=0.
//  4. Line low for 2 cycles, then high -> stays IDLE/returns to IDLE,
//     no pulses, o_busy drops by edge_cnt=H+1.
//  5. Assert i_rst at data bit 3 of 0xFF -> outputs 0 immediately; next clean
//     0x3C frame is received correctly.
//  6. Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three valid pulses,
//     correct data. Single-cycle glitch at mid-bit of a data bit -> majority
//     vote masks it.

Source files
------------

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if
//   Groups the serial-line input, the per-frame parity configuration and the
//   host-side result pulses of the UART receiver into one bundle.
//   Signals:
//     i_rx_in          serial line, idle high, asynchronous to i_clk
//     i_parity_enable  1: frame carries a parity bit
//     i_parity_type    0: even, 1: odd
//     o_data           last received data word
//     o_data_valid     1-cycle pulse: good frame in o_data
//     o_parity_error   1-cycle pulse: parity mismatch
//     o_stop_error     1-cycle pulse: stop bit sampled 0
//     o_busy           high while a frame is in progress
//   Modports:
//     slave   the receiver core
//     master  whatever drives the line and consumes the results
`timescale 1ns/1ps
interface uart_rx_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_rx_in;
  logic                  i_parity_enable;
  logic                  i_parity_type;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  o_parity_error;
  logic                  o_stop_error;
  logic                  o_busy;

  modport slave (
    input  i_rx_in, i_parity_enable, i_parity_type,
    output o_data, o_data_valid, o_parity_error, o_stop_error, o_busy
  );

  modport master (
    output i_rx_in, i_parity_enable, i_parity_type,
    input  o_data, o_data_valid, o_parity_error, o_stop_error, o_busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   UART receiver: start(0), DATA_WIDTH data bits LSB first, optional parity,
//   one stop(1). i_clk runs at OVERSAMPLE ticks per bit (>=4, even). Each bit
//   is decided by a 3-sample majority around mid-bit. Results are delivered
//   as registered 1-cycle pulses one cycle after the frame ends.
//   Ports:
//     i_clk   oversampled clock
//     i_rst   asynchronous reset, active low
//     bus     uart_rx_core_if slave: serial input, parity config, results
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  uart_rx_core_if.slave  bus
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [EW-1:0] EDGE_PRE  = EW'(H - 1);
  localparam logic [EW-1:0] EDGE_MID  = EW'(H);
  localparam logic [EW-1:0] EDGE_POST = EW'(H + 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [1:0]            samp_q, samp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop_bit_q, stop_bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;

  logic rx_s;
  logic maj;
  logic at_post;
  logic at_last;
  logic stop_val;
  logic par_mismatch;

  assign rx_s    = sync_q[1];
  assign at_post = (edge_cnt_q == EDGE_POST);
  assign at_last = (edge_cnt_q == EDGE_LAST);
  // The third sample is the live rx_s, so the vote is ready at EDGE_POST.
  assign maj     = (samp_q[0] & samp_q[1]) | (rx_s & (samp_q[0] | samp_q[1]));
  // With OVERSAMPLE=4 the stop decision and frame end share a cycle.
  assign stop_val     = at_post ? maj : stop_bit_q;
  assign par_mismatch = par_bit_q != ((^shift_q) ^ par_type_q);

  assign bus.o_data         = data_q;
  assign bus.o_data_valid   = data_valid_q;
  assign bus.o_parity_error = parity_error_q;
  assign bus.o_stop_error   = stop_error_q;
  assign bus.o_busy         = (state_q != ST_IDLE);

  always_comb begin
    state_d        = state_q;
    sync_d         = {sync_q[0], bus.i_rx_in};
    edge_cnt_d     = at_last ? '0 : edge_cnt_q + EW'(1);
    bit_cnt_d      = bit_cnt_q;
    samp_d         = samp_q;
    shift_d        = shift_q;
    par_en_d       = par_en_q;
    par_type_d     = par_type_q;
    par_bit_d      = par_bit_q;
    stop_bit_d     = stop_bit_q;
    data_d         = data_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;

    if (edge_cnt_q == EDGE_PRE) samp_d[0] = rx_s;
    if (edge_cnt_q == EDGE_MID) samp_d[1] = rx_s;

    case (state_q)
      ST_IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s) begin
          state_d    = ST_START;
          par_en_d   = bus.i_parity_enable;
          par_type_d = bus.i_parity_type;
        end
      end
      ST_START: begin
        if (at_post && maj) begin
          state_d    = ST_IDLE;
          edge_cnt_d = '0;
        end else if (at_last) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // Shifting in at the MSB end leaves the first bit at the LSB.
        if (at_post) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
        if (at_last) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (at_post) par_bit_d = maj;
        if (at_last) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (at_post) stop_bit_d = maj;
        if (at_last) begin
          state_d        = ST_IDLE;
          data_d         = shift_q;
          stop_error_d   = !stop_val;
          parity_error_d = par_en_q && par_mismatch;
          data_valid_d   = stop_val && !(par_en_q && par_mismatch);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q        <= ST_IDLE;
      sync_q         <= 2'b11;
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      samp_q         <= 2'b00;
      shift_q        <= '0;
      par_en_q       <= 1'b0;
      par_type_q     <= 1'b0;
      par_bit_q      <= 1'b0;
      stop_bit_q     <= 1'b0;
      data_q         <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      samp_q         <= samp_d;
      shift_q        <= shift_d;
      par_en_q       <= par_en_d;
      par_type_q     <= par_type_d;
      par_bit_q      <= par_bit_d;
      stop_bit_q     <= stop_bit_d;
      data_q         <= data_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

endmodule
